dmem_dma: RTL and testbench

DMEM_DMA -- requirements
Module: dmem_dma

---
 rtl/dmem_dma.sv | 168 ++++++++++++++++
 tb/tb_dmem_dma.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_dma.sv
// dmem_dma: word-by-word copy engine between two regions of a single data memory.
// Defining DMEM_DMA_FILL_EN adds a constant-fill mode (ports fill, fill_data).
module dmem_dma #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] words_done,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_data_in,
  output logic              dmem_wr,
  input  logic [DATA_W-1:0] dmem_data_out
`ifdef DMEM_DMA_FILL_EN
  ,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_data
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_src, r_dst, r_len;
  logic [ADDR_W-1:0]   r_words, w_words_next, w_words_inc;
  logic [ADDR_W-1:0]   r_addr, w_addr_next;
  logic                r_wr, w_wr_next;
  logic                r_busy, w_busy_next;
  logic                r_done, w_done_next;
  logic                w_accept;
  logic                w_fill_in, w_fill_reg;
  logic [DATA_W-1:0]   w_wdata;

  assign w_accept    = (r_state == S_IDLE) && start && (len != '0);
  assign w_words_inc = r_words + ONE;

`ifdef DMEM_DMA_FILL_EN
  logic              r_fill;
  logic [DATA_W-1:0] r_fill_data;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fill      <= 1'b0;
      r_fill_data <= '0;
    end else if (w_accept) begin
      r_fill      <= fill;
      r_fill_data <= fill_data;
    end
  end

  assign w_fill_in  = fill;
  assign w_fill_reg = r_fill;
  assign w_wdata    = r_fill ? r_fill_data : dmem_data_out;
`else
  assign w_fill_in  = 1'b0;
  assign w_fill_reg = 1'b0;
  assign w_wdata    = dmem_data_out;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_words <= '0;
      r_addr  <= '0;
      r_wr    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_words <= w_words_next;
      r_addr  <= w_addr_next;
      r_wr    <= w_wr_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      if (w_accept) begin
        r_src <= src_addr;
        r_dst <= dst_addr;
        r_len <= len;
      end
    end
  end

  // Outputs are registered, so each branch computes what the *next* state must drive.
  always_comb begin
    w_state_next = r_state;
    w_words_next = r_words;
    w_addr_next  = '0;
    w_wr_next    = 1'b0;
    w_busy_next  = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            w_words_next = '0;
            w_busy_next  = 1'b1;
            if (w_fill_in) begin
              w_state_next = S_WRITE;
              w_addr_next  = dst_addr;
              w_wr_next    = 1'b1;
            end else begin
              w_state_next = S_READ;
              w_addr_next  = src_addr;
            end
          end else begin
            w_state_next = S_DONE;
            w_done_next  = 1'b1;
          end
        end
      end
      S_READ: begin
        w_state_next = S_WRITE;
        w_busy_next  = 1'b1;
        w_addr_next  = r_dst + r_words;
        w_wr_next    = 1'b1;
      end
      S_WRITE: begin
        w_words_next = w_words_inc;
        if (w_words_inc == r_len) begin
          w_state_next = S_DONE;
          w_done_next  = 1'b1;
        end else begin
          w_busy_next = 1'b1;
          if (w_fill_reg) begin
            w_state_next = S_WRITE;
            w_addr_next  = r_dst + w_words_inc;
            w_wr_next    = 1'b1;
          end else begin
            w_state_next = S_READ;
            w_addr_next  = r_src + w_words_inc;
          end
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Read data only arrives during WRITE, so it is forwarded straight to the write port;
  // the enable is masked by reset so an aborting cycle never commits a write.
  assign dmem_wr      = r_wr & reset_n;
  assign dmem_data_in = dmem_wr ? w_wdata : '0;
  assign dmem_addr    = r_addr;
  assign busy         = r_busy;
  assign done         = r_done;
  assign words_done   = r_words;

endmodule

// File: tb/tb_dmem_dma.sv
// Bench for dmem_dma: synchronous-read memory, transfer-level reference model with per-cycle
// output checks, directed literal cases and randomized transfers (fill cases with DMEM_DMA_FILL_EN).
module tb_dmem_dma;
  localparam int AW = 16;
  localparam int DW = 32;
`ifdef DMEM_DMA_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n, start, fill;
  logic [AW-1:0] src_addr, dst_addr, len;
  logic [DW-1:0] fill_data;
  logic          busy, done, dmem_wr;
  logic [AW-1:0] words_done, dmem_addr;
  logic [DW-1:0] dmem_data_in, dmem_data_out;

  always #5 clk = ~clk;

  dmem_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .words_done(words_done),
    .dmem_addr(dmem_addr), .dmem_data_in(dmem_data_in), .dmem_wr(dmem_wr),
    .dmem_data_out(dmem_data_out)
`ifdef DMEM_DMA_FILL_EN
    , .fill(fill), .fill_data(fill_data)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Data memory: words never written read back as a fixed address hash.
  logic [DW-1:0] mem [65536];
  bit            mem_v [65536];
  logic [DW-1:0] rmem [65536];
  bit            rmem_v [65536];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return {a ^ 16'hC3A5, ~a};
  endfunction
  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem_v[a] ? mem[a] : init_word(a);
  endfunction
  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return rmem_v[a] ? rmem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr]   <= bd_data;
      mem_v[bd_addr] <= 1'b1;
    end else if (dmem_wr) begin
      mem[dmem_addr]   <= dmem_data_in;
      mem_v[dmem_addr] <= 1'b1;
    end
    dmem_data_out <= mem_rd(dmem_addr);
  end

  // Reference model: a transfer is a list of words i = 0..len-1, each read from src+i then
  // written to dst+i (copy: 2 cycles/word) or just written with fill_data (1 cycle/word).
  typedef enum int {M_IDLE, M_ACT, M_DONE} mmode_t;
  mmode_t        m_mode = M_IDLE;
  bit            m_armed = 1'b0;
  bit            m_fill = 1'b0;
  int            m_t = 0;
  logic [AW-1:0] m_src = '0, m_dst = '0, m_len = '0, m_wd = '0;
  logic [DW-1:0] m_fd = '0;

  function automatic bit m_is_write();
    return m_fill || (m_t % 2 == 0);
  endfunction
  function automatic logic [DW-1:0] m_wdata();
    logic [AW-1:0] a;
    a = m_src + m_wd;
    return m_fill ? m_fd : ref_rd(a);
  endfunction

  always @(posedge clk) begin
    logic [AW-1:0] wa;
    logic [AW-1:0] nwd;
    wa  = m_dst + m_wd;
    nwd = m_wd + 16'd1;
    if (bd_we) begin
      rmem[bd_addr]   <= bd_data;
      rmem_v[bd_addr] <= 1'b1;
    end
    if (!reset_n) begin
      m_armed <= 1'b1;
      m_mode  <= M_IDLE;
      m_wd    <= '0;
      m_t     <= 0;
    end else if (m_armed) begin
      case (m_mode)
        M_IDLE: if (start) begin
          if (len != '0) begin
            m_mode <= M_ACT;
            m_src  <= src_addr;
            m_dst  <= dst_addr;
            m_len  <= len;
            m_fill <= FILL_EN && fill;
            m_fd   <= fill_data;
            m_wd   <= '0;
            m_t    <= 1;
          end else begin
            m_mode <= M_DONE;
          end
        end
        M_ACT: begin
          if (m_is_write()) begin
            rmem[wa]   <= m_wdata();
            rmem_v[wa] <= 1'b1;
            m_wd       <= nwd;
            if (nwd == m_len) m_mode <= M_DONE;
          end
          m_t <= m_t + 1;
        end
        default: m_mode <= M_IDLE;
      endcase
    end
  end

  int done_cnt = 0;
  int wr_cnt = 0;
  int busy_cnt = 0;

  always @(negedge clk) begin
    bit            ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    if (m_armed) begin
      ew = (m_mode == M_ACT) && m_is_write() && reset_n;
      if (m_mode != M_ACT) ea = '0;
      else if (m_is_write()) ea = m_dst + m_wd;
      else ea = m_src + m_wd;
      ed = ew ? m_wdata() : '0;
      chk("busy", 32'(busy), 32'(m_mode == M_ACT));
      chk("done", 32'(done), 32'(m_mode == M_DONE));
      chk("dmem_wr", 32'(dmem_wr), 32'(ew));
      chk("dmem_addr", 32'(dmem_addr), 32'(ea));
      chk("dmem_data_in", dmem_data_in, ed);
      chk("words_done", 32'(words_done), 32'(m_wd));
      if (done) done_cnt <= done_cnt + 1;
      if (dmem_wr) wr_cnt <= wr_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
    end
  end

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic run_xfer(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] n,
                          input bit f, input logic [DW-1:0] fd, input bit junk, output int dc);
    src_addr = s; dst_addr = d; len = n; fill = FILL_EN && f; fill_data = fd; start = 1'b1;
    dc = -1;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (junk && m_mode != M_IDLE && $urandom_range(0, 1) == 1) begin
        start = 1'b1; src_addr = 16'($urandom); dst_addr = 16'($urandom);
        len = 16'($urandom); fill_data = $urandom; fill = FILL_EN && ($urandom_range(0, 1) == 1);
      end
      if (done) begin
        dc = c;
        break;
      end
    end
    start = 1'b0;
    if (dc < 0) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: actual=none required=done within 300 cycles t=%0t", $time);
    end
    @(posedge clk); #1;
    $display("xfer src=%04h dst=%04h len=%0d fill=%0d done_after=%0d words_done=%0d",
             s, d, n, f, dc, words_done);
  endtask

  task automatic run_abort(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] n,
                           input bit f, input int wait_cyc);
    src_addr = s; dst_addr = d; len = n; fill = FILL_EN && f; fill_data = $urandom; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < wait_cyc; c++) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    $display("abort src=%04h dst=%04h len=%0d fill=%0d reset_after=%0d", s, d, n, f, wait_cyc + 1);
  endtask

  initial begin
    int dc, w0, b0, d0, nbad;
    logic [AW-1:0] s, d, n;
    reset_n = 1'b0; start = 1'b0; fill = 1'b0; fill_data = '0;
    src_addr = '0; dst_addr = '0; len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_wr", 32'(dmem_wr), 32'd0);
    chk("reset_addr", 32'(dmem_addr), 32'd0);
    chk("reset_words", 32'(words_done), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Plain 4-word copy.
    poke(16'h0010, 32'hAAAA_0001); poke(16'h0011, 32'hBBBB_0002);
    poke(16'h0012, 32'hCCCC_0003); poke(16'h0013, 32'hDDDD_0004);
    run_xfer(16'h0010, 16'h0100, 16'd4, 1'b0, '0, 1'b0, dc);
    chk("copy4_done_cycles", 32'(dc), 32'd9);
    chk("copy4_w0", mem_rd(16'h0100), 32'hAAAA_0001);
    chk("copy4_w1", mem_rd(16'h0101), 32'hBBBB_0002);
    chk("copy4_w2", mem_rd(16'h0102), 32'hCCCC_0003);
    chk("copy4_w3", mem_rd(16'h0103), 32'hDDDD_0004);
    chk("copy4_model_w3", ref_rd(16'h0103), 32'hDDDD_0004);
    chk("copy4_words_done", 32'(words_done), 32'd4);

    // Zero-length request.
    w0 = wr_cnt; b0 = busy_cnt;
    run_xfer(16'h0055, 16'h0155, 16'd0, 1'b0, '0, 1'b0, dc);
    chk("len0_done_cycles", 32'(dc), 32'd1);
    chk("len0_writes", 32'(wr_cnt - w0), 32'd0);
    chk("len0_busy_cycles", 32'(busy_cnt - b0), 32'd0);

    // Source wraps from 0xFFFF to 0x0000.
    poke(16'hFFFF, 32'h1234_5678); poke(16'h0000, 32'h9ABC_DEF0);
    run_xfer(16'hFFFF, 16'h0200, 16'd2, 1'b0, '0, 1'b1, dc);
    chk("wrap_w0", mem_rd(16'h0200), 32'h1234_5678);
    chk("wrap_w1", mem_rd(16'h0201), 32'h9ABC_DEF0);
    chk("wrap_done_cycles", 32'(dc), 32'd5);

    // Overlap with dst = src + 1 replicates the first word.
    poke(16'h0020, 32'hCAFE_0020); poke(16'h0021, 32'h1111_1111);
    poke(16'h0022, 32'h2222_2222); poke(16'h0023, 32'h3333_3333);
    run_xfer(16'h0020, 16'h0021, 16'd3, 1'b0, '0, 1'b0, dc);
    chk("overlap_w1", mem_rd(16'h0021), 32'hCAFE_0020);
    chk("overlap_w2", mem_rd(16'h0022), 32'hCAFE_0020);
    chk("overlap_w3", mem_rd(16'h0023), 32'hCAFE_0020);

    // Reset during the second WRITE of a 4-word copy.
    for (int i = 0; i < 4; i++) begin
      poke(16'(16'h0040 + i), 32'(32'hE0E0_0000 + i));
      poke(16'(16'h0140 + i), 32'h0);
    end
    d0 = done_cnt;
    src_addr = 16'h0040; dst_addr = 16'h0140; len = 16'd4; fill = 1'b0; start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("abort_in_write2_addr", 32'(dmem_addr), 32'h0141);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_wr", 32'(dmem_wr), 32'd0);
    chk("abort_addr", 32'(dmem_addr), 32'd0);
    chk("abort_data_in", dmem_data_in, 32'd0);
    chk("abort_words", 32'(words_done), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_dst0", mem_rd(16'h0140), 32'hE0E0_0000);
    chk("abort_dst1", mem_rd(16'h0141), 32'h0);
    chk("abort_dst3", mem_rd(16'h0143), 32'h0);
    $display("abort src=0040 dst=0140 len=4 reset_in_second_write");

`ifdef DMEM_DMA_FILL_EN
    run_xfer(16'h0000, 16'h0300, 16'd3, 1'b1, 32'hDEAD_BEEF, 1'b1, dc);
    chk("fill_done_cycles", 32'(dc), 32'd4);
    chk("fill_w0", mem_rd(16'h0300), 32'hDEAD_BEEF);
    chk("fill_w2", mem_rd(16'h0302), 32'hDEAD_BEEF);
    chk("fill_words_done", 32'(words_done), 32'd3);
`endif

    // Randomized transfers, some aborted by reset, with busy-time start noise.
    for (int k = 0; k < 60; k++) begin
      s = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7)) : 16'($urandom);
      d = ($urandom_range(0, 3) == 0) ? 16'(s + $urandom_range(0, 4)) : 16'($urandom);
      n = 16'($urandom_range(0, 10));
      if ($urandom_range(0, 7) == 0)
        run_abort(s, d, n, $urandom_range(0, 1) == 1, int'($urandom_range(0, 12)));
      else
        run_xfer(s, d, n, $urandom_range(0, 3) == 0, $urandom, 1'b1, dc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    nbad = 0;
    for (int a = 0; a < 65536; a++)
      if (mem_rd(16'(a)) !== ref_rd(16'(a))) nbad++;
    chk("memory_image_mismatch_words", 32'(nbad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
